tdm_demux_8x1: RTL and testbench
================================

# tdm_demux_8x1

Registered 1-to-8 time-division demultiplexer: the receive end of the 8:1 channel-select path. A serial stream carries one bit per slot, slots 0..7 in order, with slot 0 flagged by a sync strobe. The block tracks the slot index, collects one full frame, and presents all eight channel bits in parallel with a one-cycle frame-valid pulse. It sits directly downstream of a scanned 8:1 mux or a serial link and feeds parallel channel logic.

## Interface

- NCH, 8, number of channels (fixed at 8; slot index is 3 bits)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- din  input  1  serial data bit for the current slot
- en  input  1  slot strobe; din/sync sampled only when en=1
- sync  input  1  marks the en cycle carrying slot 0
- b  output  8  last complete frame; b[k] = bit received in slot k
- slot  output  3  index of the next slot to be written
- frame_valid  output  1  one-cycle pulse: b has just been updated
- sync_err  output  1  one-cycle pulse: sync arrived at slot≠0 while locked
- locked  output  1  1 in LOCKED state

## Operation

- States: HUNT, LOCKED.
- HUNT: en=1 with sync=0 ignored. en=1 with sync=1 → shadow[0]<=din, slot<=1, go to LOCKED.
- LOCKED, en=1, sync=0: shadow[slot]<=din, slot<=slot+1 (3-bit wrap 7→0).
- LOCKED, en=1, slot=7: b<={din, shadow[6:0]}, frame_valid<=1, slot<=0.
- LOCKED, en=1, sync=1, slot=0: normal slot-0 write.
- LOCKED, en=1, sync=1, slot≠0: partial frame discarded (b unchanged, no frame_valid), sync_err<=1, shadow[0]<=din, slot<=1, stay LOCKED.
- LOCKED, en=1, sync=0, slot=0: accepted as slot 0 (flywheel; no error).
- en=0: all state held; frame_valid and sync_err return to 0.
- Shadow bits not written in the current frame keep old values; only a completed frame reaches b.

## Timing

- Reset (rst=1 at a clock edge): b=8'h00, slot=0, frame_valid=0, sync_err=0, locked=0, shadow=0, state HUNT. Reset mid-frame discards the frame; no pulse issued.
- All outputs registered; no combinational path from inputs to outputs.
- Latency: frame_valid and new b visible the cycle after the en edge sampling slot 7.
- Back-to-back frames at en=1 every cycle: frame_valid high 1 cycle in every 8.
- frame_valid and sync_err are never both 1 in the same cycle.
- rst has priority over all inputs.

## Structure

- Shared package tdm_pkg: NCH=8, SLOT_W=3, state enum {HUNT, LOCKED}.
- One sub-module: tdm_slot_ctr (3-bit counter with load-to-1 on sync, increment on en, wrap).
- Top holds FSM, 7-bit shadow register, 8-bit output register, pulse flops.

## Test plan

- Reset then sync + din pattern 1,0,1,1,0,0,1,0 on 8 consecutive en cycles → next cycle b=8'h4D, frame_valid=1 for 1 cycle, slot=0.
- In HUNT, 5 en cycles with sync=0 → locked=0, slot=0, b=8'h00, no pulses.
- Locked, sync=1 at slot 4 → sync_err=1 for 1 cycle, slot=1, b unchanged; then 7 more bits all 1 with din=1 at sync → b=8'hFF, frame_valid.
- en toggled 1/0 through a frame of all-1 bits → frame completes after 8 en-high cycles only; b=8'hFF; slot frozen when en=0.
- Two back-to-back frames 8'hA5 then 8'h3C, sync only on first → frame_valid 8 cycles apart, b=8'hA5 then 8'h3C, no sync_err.
- rst asserted at slot 5 → all outputs reset next cycle; no frame_valid; next sync restarts cleanly.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg
// Shared definitions for the 8-channel TDM receive path: channel count,
// slot index width, slot index type and the framing state enum.
package tdm_pkg;

    localparam int NCH    = 8;
    localparam int SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    // HUNT: waiting for the first sync strobe.
    // LOCKED: tracking slots and assembling frames.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam slot_t LAST_SLOT = slot_t'(NCH - 1);

endpackage : tdm_pkg

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr
// Slot index counter for the TDM receiver. Loads 1 when a frame is
// (re)started on the slot-0 strobe, increments with natural 3-bit wrap
// (7 -> 0) on every accepted slot, otherwise holds.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (slot -> 0)
//   load_i  force slot index to 1 (slot 0 has just been taken)
//   inc_i   advance slot index by one, wrapping 7 -> 0
//   slot_o  registered slot index of the next slot to be written
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  inc_i,
    output slot_t slot_o
);

    slot_t slot_q;
    slot_t slot_d;

    // load wins over inc; the top never asserts both, but the order keeps
    // a resync deterministic if it ever did.
    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = slot_t'(1);
        end else if (inc_i) begin
            slot_d = slot_q + slot_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule : tdm_slot_ctr

// File: rtl/tdm_demux_8x1.sv
// tdm_demux_8x1
// Registered 1-to-8 time-division demultiplexer. A serial stream carries
// one bit per slot (slots 0..7, slot 0 flagged by sync). Bits are gathered
// in a 7-bit shadow register; the slot-7 bit completes the frame and the
// whole frame is transferred to b with a one-cycle frame_valid pulse.
// A sync seen mid-frame while locked discards the partial frame, pulses
// sync_err and restarts at slot 1 with din taken as slot 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, priority over all inputs
//   din          serial data bit for the current slot
//   en           slot strobe; din/sync sampled only when en=1
//   sync         marks the en cycle carrying slot 0
//   b            last complete frame, b[k] = bit received in slot k
//   slot         index of the next slot to be written
//   frame_valid  one-cycle pulse, b has just been updated
//   sync_err     one-cycle pulse, sync arrived at slot!=0 while locked
//   locked       1 while in LOCKED state
module tdm_demux_8x1
    import tdm_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           din,
    input  logic           en,
    input  logic           sync,
    output logic [NCH-1:0] b,
    output logic [SLOT_W-1:0] slot,
    output logic           frame_valid,
    output logic           sync_err,
    output logic           locked
);

    state_e         state_q;
    state_e         state_d;
    slot_t          slot_q;
    logic [NCH-2:0] shadow_q;
    logic [NCH-2:0] shadow_d;
    logic [NCH-1:0] b_q;
    logic [NCH-1:0] b_d;
    logic           frame_valid_q;
    logic           sync_err_q;

    logic is_locked;
    logic start_lock;   // first sync while hunting
    logic sync_mis;     // sync at a non-zero slot while locked
    logic slot_wr;      // normal in-order slot write while locked
    logic frame_done;   // slot-7 write completes the frame
    logic ctr_load;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign is_locked  = (state_q == LOCKED);
    assign start_lock = en && sync && !is_locked;
    assign sync_mis   = en && sync && is_locked && (slot_q != slot_t'(0));
    // Covers both sync=1 at slot 0 and the flywheel case (sync=0 at slot 0).
    assign slot_wr    = en && is_locked && !sync_mis;
    assign frame_done = slot_wr && (slot_q == LAST_SLOT);
    assign ctr_load   = start_lock || sync_mis;

    tdm_slot_ctr u_slot_ctr (
        .clk    (clk),
        .rst    (rst),
        .load_i (ctr_load),
        .inc_i  (slot_wr),
        .slot_o (slot_q)
    );

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Once locked, the block never returns to HUNT except via reset;
    // misaligned syncs are handled by resynchronising in place.
    always_comb begin
        state_d = state_q;
        if (start_lock) begin
            state_d = LOCKED;
        end
    end

    always_comb begin
        locked = is_locked;
    end

    // ------------------------------------------------------------------
    // Shadow register: slot k (0..6) lands in shadow bit k. Slot 0 is also
    // written on a (re)start. Unwritten bits keep their previous values.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH - 1; gi++) begin : g_shadow
        logic wr;
        assign wr = (slot_wr && (slot_q == slot_t'(gi))) ||
                    (ctr_load && (gi == 0));
        assign shadow_d[gi] = wr ? din : shadow_q[gi];
    end

    // The slot-7 bit bypasses the shadow and goes straight into b together
    // with the seven stored bits.
    always_comb begin
        b_d = b_q;
        if (frame_done) begin
            b_d = {din, shadow_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q      <= '0;
            b_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            b_q           <= b_d;
            // frame_done and sync_mis are mutually exclusive by construction,
            // so the two pulses can never coincide.
            frame_valid_q <= frame_done;
            sync_err_q    <= sync_mis;
        end
    end

    assign b           = b_q;
    assign slot        = slot_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;

endmodule : tdm_demux_8x1

// File: tb/tb_tdm_demux_8x1.sv
module tb_tdm_demux_8x1;

    logic       clk;
    logic       rst;
    logic       din;
    logic       en;
    logic       sync;
    logic [7:0] b;
    logic [2:0] slot;
    logic       frame_valid;
    logic       sync_err;
    logic       locked;

    int total;
    int bad;
    int fv_cnt;
    int se_cnt;

    tdm_demux_8x1 dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .en          (en),
        .sync        (sync),
        .b           (b),
        .slot        (slot),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, let the rising edge
    // take them, then look at the registered outputs 1 ns later.
    task automatic cyc(input logic r, input logic e, input logic s, input logic d);
        @(negedge clk);
        rst  = r;
        en   = e;
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
        fv_cnt += int'(frame_valid);
        se_cnt += int'(sync_err);
        $display("t=%0t rst=%0b en=%0b sync=%0b din=%0b -> b=%02h slot=%0d fv=%0b se=%0b locked=%0b",
                 $time, r, e, s, d, b, slot, frame_valid, sync_err, locked);
        total++;
        if (frame_valid === 1'b1 && sync_err === 1'b1) begin
            bad++;
            $display("FAIL pulse_overlap: got fv=1 se=1 required not both");
        end
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        total++; if (b !== 8'h00) begin bad++; $display("FAIL reset_b: got %02h required 00", b); end
        total++; if (slot !== 3'd0) begin bad++; $display("FAIL reset_slot: got %0d required 0", slot); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %0b required 0", frame_valid); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL reset_se: got %0b required 0", sync_err); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b required 0", locked); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hunt();
        fv_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'(i & 1));
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL hunt_locked: got %0b required 0", locked); end
        total++; if (slot !== 3'd0) begin bad++; $display("FAIL hunt_slot: got %0d required 0", slot); end
        total++; if (b !== 8'h00) begin bad++; $display("FAIL hunt_b: got %02h required 00", b); end
        total++; if (fv_cnt != 0 || se_cnt != 0) begin bad++; $display("FAIL hunt_pulses: got fv=%0d se=%0d required 0 0", fv_cnt, se_cnt); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] fr;
        fr = 8'h4D;   // slot bits 1,0,1,1,0,0,1,0
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, (i == 0), fr[i]);
            if (i == 0) begin
                total++; if (slot !== 3'd1 || locked !== 1'b1) begin bad++; $display("FAIL basic_lock: got slot=%0d locked=%0b required 1 1", slot, locked); end
            end
            if (i == 6) begin
                total++; if (frame_valid !== 1'b0 || b !== 8'h00) begin bad++; $display("FAIL basic_early: got fv=%0b b=%02h required 0 00", frame_valid, b); end
            end
        end
        total++; if (b !== 8'h4D) begin bad++; $display("FAIL basic_b: got %02h required 4d", b); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv: got %0b required 1", frame_valid); end
        total++; if (slot !== 3'd0) begin bad++; $display("FAIL basic_slot: got %0d required 0", slot); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (frame_valid !== 1'b0 || b !== 8'h4D) begin bad++; $display("FAIL basic_fv_drop: got fv=%0b b=%02h required 0 4d", frame_valid, b); end
    endtask

    task automatic test_sync_err();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (slot !== 3'd4) begin bad++; $display("FAIL serr_pre_slot: got %0d required 4", slot); end
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL serr_pulse: got %0b required 1", sync_err); end
        total++; if (slot !== 3'd1) begin bad++; $display("FAIL serr_slot: got %0d required 1", slot); end
        total++; if (b !== 8'h4D || frame_valid !== 1'b0) begin bad++; $display("FAIL serr_b: got b=%02h fv=%0b required 4d 0", b, frame_valid); end
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
            if (i == 1) begin
                total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL serr_drop: got %0b required 0", sync_err); end
            end
        end
        total++; if (b !== 8'hFF || frame_valid !== 1'b1) begin bad++; $display("FAIL serr_frame: got b=%02h fv=%0b required ff 1", b, frame_valid); end
    endtask

    task automatic test_en_toggle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        fv_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, (i == 0), 1'b1);
            if (i < 7) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
                total++; if (slot !== 3'(i + 1) || frame_valid !== 1'b0) begin bad++; $display("FAIL toggle_hold%0d: got slot=%0d fv=%0b required %0d 0", i, slot, frame_valid, i + 1); end
            end
        end
        total++; if (b !== 8'hFF || frame_valid !== 1'b1 || fv_cnt != 1) begin bad++; $display("FAIL toggle_frame: got b=%02h fv=%0b cnt=%0d required ff 1 1", b, frame_valid, fv_cnt); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (slot !== 3'd0 || frame_valid !== 1'b0) begin bad++; $display("FAIL toggle_idle: got slot=%0d fv=%0b required 0 0", slot, frame_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] frs;
        int fv_at[$];
        frs = 16'h3CA5;   // low byte first frame, high byte second
        fv_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, (i == 0), frs[i]);
            if (frame_valid === 1'b1) fv_at.push_back(i);
            if (i == 7) begin
                total++; if (b !== 8'hA5 || frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_first: got b=%02h fv=%0b required a5 1", b, frame_valid); end
            end
        end
        total++; if (b !== 8'h3C || frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_second: got b=%02h fv=%0b required 3c 1", b, frame_valid); end
        total++; if (fv_at.size() != 2 || fv_at[1] - fv_at[0] != 8) begin bad++; $display("FAIL b2b_spacing: got %0d pulses required 2 pulses 8 apart", fv_at.size()); end
        total++; if (se_cnt != 0) begin bad++; $display("FAIL b2b_se: got %0d required 0", se_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] fr;
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        total++; if (slot !== 3'd5) begin bad++; $display("FAIL rmid_pre_slot: got %0d required 5", slot); end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (b !== 8'h00 || slot !== 3'd0 || locked !== 1'b0) begin bad++; $display("FAIL rmid_state: got b=%02h slot=%0d locked=%0b required 00 0 0", b, slot, locked); end
        total++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("FAIL rmid_pulses: got fv=%0b se=%0b required 0 0", frame_valid, sync_err); end
        fr = 8'h96;
        fv_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i == 0), fr[i]);
        total++; if (b !== 8'h96 || frame_valid !== 1'b1) begin bad++; $display("FAIL rmid_restart: got b=%02h fv=%0b required 96 1", b, frame_valid); end
        total++; if (fv_cnt != 1 || se_cnt != 0) begin bad++; $display("FAIL rmid_counts: got fv=%0d se=%0d required 1 0", fv_cnt, se_cnt); end
    endtask

    initial begin
        total = 0; bad = 0; fv_cnt = 0; se_cnt = 0;
        rst = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
        test_reset();
        test_hunt();
        test_basic_frame();
        test_sync_err();
        test_en_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tdm_demux_8x1
